// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared DES key-schedule widths, shift schedule, state enum and rotate helper
package des_pkg;

    localparam int DES_HALF_W   = 28;
    localparam int DES_KEY_W    = 56;
    localparam int DES_SUBKEY_W = 48;

    // Bit i describes round i+1: 1 = rotate by two, 0 = rotate by one.
    localparam logic [15:0] DES_SHIFT_SCHED = 16'h7EFC;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } key_sched_state_t;

    // dir 0 = left (encrypt), 1 = right (decrypt); two selects a double rotation.
    function automatic logic [DES_HALF_W-1:0] rot28(
        input logic [DES_HALF_W-1:0] val,
        input logic                  dir,
        input logic                  two
    );
        logic [DES_HALF_W-1:0] r;
        if (!dir) begin
            r = two ? {val[25:0], val[27:26]} : {val[26:0], val[27]};
        end else begin
            r = two ? {val[1:0], val[27:2]} : {val[0], val[27:1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/permute_out.sv
// rtl/permute_out.sv - DES PC-2 compression of the 56-bit {C,D} into a 48-bit round subkey
module permute_out
    import des_pkg::*;
(
    input  logic [DES_KEY_W-1:0]    cd,
    output logic [DES_SUBKEY_W-1:0] subkey
);

    // Standard PC-2 table, 1-based with bit 1 being the MSB of {C,D}.
    localparam int PC2_TAB [DES_SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    for (genvar j = 0; j < DES_SUBKEY_W; j++) begin : g_pc2
        assign subkey[DES_SUBKEY_W-1-j] = cd[DES_KEY_W-PC2_TAB[j]];
    end

endmodule

// File: rtl/des_key_sched_ctrl.sv
// rtl/des_key_sched_ctrl.sv - DES C/D rotation sequencer with valid/ready subkey output
// Optional: DES_KEY_ZEROIZE_EN clears C/D on the final accept so idle subkey reads 0.
module des_key_sched_ctrl
    import des_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [DES_KEY_W-1:0]    key_in,
    input  logic                    decrypt,
    input  logic                    subkey_ready,
    output logic [DES_SUBKEY_W-1:0] subkey,
    output logic                    subkey_valid,
    output logic [3:0]              round,
    output logic                    busy,
    output logic                    done
);

    key_sched_state_t      state_q, state_d;
    logic [DES_HALF_W-1:0] c_q, d_q;
    logic [3:0]            round_q;
    logic                  dec_q;
    logic                  done_q;

    logic accept;
    logic last;
    logic shift_two;

    assign accept = (state_q == RUN) && subkey_ready;
    assign last   = (round_q == 4'd15);

    // Decrypt walks the schedule backwards, undoing the shift that produced the current key.
    assign shift_two = dec_q ? DES_SHIFT_SCHED[4'd15 - round_q]
                             : DES_SHIFT_SCHED[round_q + 4'd1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        busy         = 1'b0;
        subkey_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy         = 1'b1;
                subkey_valid = 1'b1;
                if (accept && last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if ((state_q == IDLE) && start) begin
                dec_q   <= decrypt;
                round_q <= '0;
                // The unrotated halves already sit at the K16 position after 28 total shifts.
                if (decrypt) begin
                    c_q <= key_in[DES_KEY_W-1:DES_HALF_W];
                    d_q <= key_in[DES_HALF_W-1:0];
                end else begin
                    c_q <= rot28(key_in[DES_KEY_W-1:DES_HALF_W], 1'b0, 1'b0);
                    d_q <= rot28(key_in[DES_HALF_W-1:0], 1'b0, 1'b0);
                end
            end else if (accept) begin
                if (last) begin
                    round_q <= '0;
                    done_q  <= 1'b1;
`ifdef DES_KEY_ZEROIZE_EN
                    c_q     <= '0;
                    d_q     <= '0;
`endif
                end else begin
                    round_q <= round_q + 4'd1;
                    c_q     <= rot28(c_q, dec_q, shift_two);
                    d_q     <= rot28(d_q, dec_q, shift_two);
                end
            end
        end
    end

    permute_out u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (subkey)
    );

    assign round = round_q;
    assign done  = done_q;

endmodule
